// File: rtl/aha_clock_switch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aha_clock_switch_sequencer
//  Description : Sequences one clock-divider select change per request for the
//                platform clock controller. Each change force-gates the
//                affected domains, switches the select, waits for the
//                selector output to settle, then ungates.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK                 in   1  control clock, rising edge
//    RESET               in   1  synchronous active-high reset
//    REQ_VALID           in   1  select-change request valid
//    REQ_READY           out  1  high only while idle (state == IDLE)
//    REQ_DOMAIN          in   2  0=SYS 1=TLX_FWD 2=CGRA 3=PERIPH
//    REQ_SELECT          in   3  divider code 0..5 (div 1..32)
//    SYS_CLK_SELECT      out  3  registered select, system clock
//    TLX_FWD_CLK_SELECT  out  3  registered select, TLX FWD clock
//    CGRA_CLK_SELECT     out  3  registered select, CGRA clock
//    PERIPH_CLK_SELECT   out  3  registered select, peripheral clock
//    FORCE_GATE          out  4  per-domain gate [0]SYS [1]TLX [2]CGRA [3]PERIPH
//    BUSY                out  1  high while gating or settling
//    DONE_PULSE          out  1  one-cycle pulse on request completion
//    ERR_PULSE           out  1  one-cycle pulse on request rejection
// ============================================================================
module aha_clock_switch_sequencer #(
    parameter int GATE_WAIT   = 8,
    parameter int SETTLE_WAIT = 32,
    parameter int CNT_W       = 6
) (
    input  wire logic       CLK,
    input  wire logic       RESET,
    input  wire logic       REQ_VALID,
    output logic            REQ_READY,
    input  wire logic [1:0] REQ_DOMAIN,
    input  wire logic [2:0] REQ_SELECT,
    output logic [2:0]      SYS_CLK_SELECT,
    output logic [2:0]      TLX_FWD_CLK_SELECT,
    output logic [2:0]      CGRA_CLK_SELECT,
    output logic [2:0]      PERIPH_CLK_SELECT,
    output logic [3:0]      FORCE_GATE,
    output logic            BUSY,
    output logic            DONE_PULSE,
    output logic            ERR_PULSE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATE   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_gate_load   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_WAIT - 1);
    localparam logic [2:0]       c_max_select  = 3'd5;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dom;
    logic [2:0]       r_sel;

    logic [2:0]       w_cur_sel;
    logic [3:0]       w_mask;

    assign REQ_READY = (r_state == S_IDLE);

    // Current select of the requested domain, used for no-op detection.
    always_comb begin
        w_cur_sel = SYS_CLK_SELECT;
        case (REQ_DOMAIN)
            2'd0:    w_cur_sel = SYS_CLK_SELECT;
            2'd1:    w_cur_sel = TLX_FWD_CLK_SELECT;
            2'd2:    w_cur_sel = CGRA_CLK_SELECT;
            default: w_cur_sel = PERIPH_CLK_SELECT;
        endcase
    end

    // The peripheral divider is derived from SYS, so a SYS change must also
    // gate the peripheral domain.
    always_comb begin
        w_mask = 4'b0000;
        case (REQ_DOMAIN)
            2'd0:    w_mask = 4'b1001;
            2'd1:    w_mask = 4'b0010;
            2'd2:    w_mask = 4'b0100;
            default: w_mask = 4'b1000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_dom              <= 2'd0;
            r_sel              <= 3'd0;
            SYS_CLK_SELECT     <= 3'd0;
            TLX_FWD_CLK_SELECT <= 3'd0;
            CGRA_CLK_SELECT    <= 3'd0;
            PERIPH_CLK_SELECT  <= 3'd0;
            FORCE_GATE         <= 4'b0000;
            BUSY               <= 1'b0;
            DONE_PULSE         <= 1'b0;
            ERR_PULSE          <= 1'b0;
        end else begin
            DONE_PULSE <= 1'b0;
            ERR_PULSE  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        if (REQ_SELECT > c_max_select) begin
                            ERR_PULSE <= 1'b1;
                        end else if (REQ_SELECT == w_cur_sel) begin
                            DONE_PULSE <= 1'b1;
                        end else begin
                            r_dom      <= REQ_DOMAIN;
                            r_sel      <= REQ_SELECT;
                            FORCE_GATE <= w_mask;
                            BUSY       <= 1'b1;
                            r_cnt      <= c_gate_load;
                            r_state    <= S_GATE;
                        end
                    end
                end
                S_GATE: begin
                    if (r_cnt == '0) begin
                        // Domains are gated; switching the select is glitch-safe.
                        case (r_dom)
                            2'd0:    SYS_CLK_SELECT     <= r_sel;
                            2'd1:    TLX_FWD_CLK_SELECT <= r_sel;
                            2'd2:    CGRA_CLK_SELECT    <= r_sel;
                            default: PERIPH_CLK_SELECT  <= r_sel;
                        endcase
                        r_cnt   <= c_settle_load;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        FORCE_GATE <= 4'b0000;
                        BUSY       <= 1'b0;
                        DONE_PULSE <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
